keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad by strobing one column at a time and sampling the rows.
- Debounces the sweep results and outputs a 4-bit key code plus a held-level `key_valid`.
- Sits directly upstream of the level-to-pulse stage: `key_valid` drives its `level` input, so each debounced press produces exactly one pulse to the code-entry logic.

Parameters:
- SCAN_DIV, 100_000: clk cycles each column is driven before rows are sampled (1 ms at 100 MHz); minimum 4.
- DEBOUNCE, 4: consecutive agreeing sweeps needed to accept a press or a release; range 2..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  keypad row pins, active-low, externally pulled up, asynchronous to clk.
- cols  out  4  column drive, active-low one-hot; non-driven columns are held 1.
- key  out  4  code of the accepted key = row*4 + col.
- key_valid  out  1  high while a debounced single key is held.
- key_multi  out  1  high when the most recent sweep saw two or more keys.

Behaviour:
- Reset (reset=0, asynchronous, takes effect without a clock edge):
  - cols=4'b1110, key=0, key_valid=0, key_multi=0.
  - FSM=IDLE, divider=0, column index c=0, debounce count=0, row synchroniser=4'b1111.
- Row synchroniser: 2 flops on rows. All sampling uses the synchronised value.
- Divider: counts 0..SCAN_DIV-1, then wraps. tick = (divider==SCAN_DIV-1).
- Column drive: cols = ~(1<<c).
- On tick: synced rows are sampled for column c, then c advances; 3 wraps to 0.
  - Sampling at the end of the dwell gives SCAN_DIV cycles of settling.
- Sweep accumulation: columns 0..3, one sample each.
  - Tracks the number of pressed intersections (saturate at 2).
  - Tracks the code of the first press found (lowest column, then lowest row).
- Sweep-end edge: the tick edge sampling column 3. The sweep result is none, single(code) or multi.
  - The accumulators clear on this same edge for the next sweep.
- key_multi is registered at every sweep-end edge: 1 iff the result is multi.
- FSM, evaluated only on sweep-end edges. cnt = debounce counter, cand = candidate code.
  - IDLE (key_valid=0):
    - single(x) -> CONFIRM_PRESS, cand=x, cnt=1.
    - otherwise stay.
  - CONFIRM_PRESS (key_valid=0):
    - single(cand) -> cnt+1. If cnt+1==DEBOUNCE -> HELD, key<=cand, key_valid<=1.
    - single(y≠cand) -> restart, cand=y, cnt=1.
    - none or multi -> IDLE.
  - HELD (key_valid=1):
    - single(key) -> stay.
    - none, multi or different single -> CONFIRM_RELEASE, cnt=1.
  - CONFIRM_RELEASE (key_valid=1):
    - single(key) -> HELD.
    - otherwise cnt+1. If cnt+1==DEBOUNCE -> IDLE, key_valid<=0.
- Key changes: a new key is never accepted directly out of HELD or CONFIRM_RELEASE. The FSM must pass through IDLE, so `key` cannot change while key_valid=1.
- After release, `key` retains the last accepted code. `key_valid` alone qualifies it.
- key_valid latency: rises on the sweep-end edge of the DEBOUNCE-th consecutive full sweep containing the press. Worst case is (DEBOUNCE+1)*4*SCAN_DIV+2 cycles after the pin changes.
- Release latency: key_valid falls after DEBOUNCE consecutive non-matching sweeps.
- Simultaneous events:
  - Reset dominates everything.
  - A multi sweep never produces a press.
  - A press appearing mid-sweep counts only from the sweep in which all columns see it consistently. A partial sweep is a valid single if only one intersection was seen.
- Reset mid-operation: outputs clear immediately. After reset deasserts, scanning restarts at column 0 with no carried-over debounce state.

Test Plan (SCAN_DIV=4, DEBOUNCE=3):
- Reset and column rotation: hold reset=0 -> cols=1110, key=0, key_valid=0, key_multi=0 with no clk edge needed. Release reset -> cols steps 1110, 1101, 1011, 0111, 1110, changing every 4 clks.
- Single press and release: model row1/col2, i.e. rows[1]=0 whenever cols[2]=0, held. -> key=6, key_valid=1 at the 3rd complete sweep-end edge, and stays high. Remove the press -> key_valid=0 at the 3rd empty sweep-end edge. The downstream level-to-pulse stage emits exactly 1 pulse.
- Bounce: the press is present for 1 sweep, absent 1, present 2, absent 1, repeated -> key_valid stays 0 throughout.
- Multi-key: keys 0 and 15 pressed together from IDLE -> key_multi=1 at the next sweep-end edge and key_valid stays 0. Then with key 5 HELD, add key 9 -> key_multi=1, and key_valid falls after 3 sweeps with key still 5.
- Release glitch: key 5 HELD, one sweep empty, then key 5 again -> key_valid stays 1 continuously and the FSM returns to HELD.
- Async reset mid-hold: key 10 HELD, drive reset=0 between clk edges -> key_valid=0 and cols=1110 immediately. After reset=1 with the key still held -> key_valid returns after 3 full sweeps.

Source files
------------

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time. It samples the
//   rows at the end of each column dwell and builds a per-sweep result: none,
//   single(code) or multi. A debounce FSM turns consecutive agreeing sweeps into
//   a held key_valid level with a stable key code.
//
// Parameters
//   SCAN_DIV  clk cycles each column is driven before the rows are sampled (>= 4)
//   DEBOUNCE  consecutive agreeing sweeps needed to accept a press or a release (2..15)
//
// Ports
//   clk        system clock
//   reset      asynchronous reset, active low
//   rows[3:0]  keypad row pins, active low, asynchronous to clk
//   cols[3:0]  column drive, active-low one-hot
//   key[3:0]   last accepted key code = row*4 + col
//   key_valid  high while a debounced single key is held
//   key_multi  high when the most recent sweep saw two or more keys
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV = 100_000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_multi
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM_PRESS,
        HELD,
        CONFIRM_RELEASE
    } state_e;

    // Row synchroniser
    logic [3:0]       rows_meta_q, rows_sync_q;

    // Column timing
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic             tick, sweep_end;

    // Sweep accumulators: hit count saturates at 2, first_q is the code of
    // the first press found in column-then-row order.
    logic [1:0]       hits_q, hits_d;
    logic [3:0]       first_q, first_d;

    // Current-column analysis and the sweep result it completes
    logic [3:0]       col_rows;
    logic [2:0]       col_hits;
    logic [1:0]       row_first;
    logic [2:0]       hit_sum;
    logic [1:0]       sweep_hits;
    logic [3:0]       sweep_code;
    logic             sweep_single;

    // Debounce FSM
    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_q, key_d;
    logic             key_multi_q, key_multi_d;

    assign tick      = (div_q == DIV_LAST);
    // The sweep ends on the tick that samples the last column.
    assign sweep_end = tick && (col_q == 2'd3);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        col_rows  = ~rows_sync_q;
        col_hits  = 3'd0;
        row_first = 2'd0;
        // Walk from the top row down so the lowest pressed row wins.
        for (int r = 3; r >= 0; r--) begin
            if (col_rows[r]) begin
                col_hits  = col_hits + 3'd1;
                row_first = 2'(r);
            end
        end
        hit_sum      = {1'b0, hits_q} + col_hits;
        sweep_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        // Earlier columns take priority for the reported code.
        sweep_code   = (hits_q != 2'd0) ? first_q : {row_first, col_q};
        sweep_single = (sweep_hits == 2'd1);
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        col_d   = tick ? col_q + 2'd1 : col_q;
        hits_d  = hits_q;
        first_d = first_q;
        if (tick) begin
            if (sweep_end) begin
                hits_d  = 2'd0;
                first_d = 4'd0;
            end else begin
                hits_d  = sweep_hits;
                first_d = sweep_code;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_d       = key_q;
        key_multi_d = key_multi_q;
        if (sweep_end) begin
            key_multi_d = (sweep_hits == 2'd2);
            case (state_q)
                IDLE: begin
                    if (sweep_single) begin
                        state_d = CONFIRM_PRESS;
                        cand_d  = sweep_code;
                        cnt_d   = 4'd1;
                    end
                end
                CONFIRM_PRESS: begin
                    if (sweep_single && (sweep_code == cand_q)) begin
                        if (4'(cnt_q + 4'd1) == DB_LAST) begin
                            state_d = HELD;
                            key_d   = cand_q;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (sweep_single) begin
                        cand_d = sweep_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!(sweep_single && (sweep_code == key_q))) begin
                        state_d = CONFIRM_RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                CONFIRM_RELEASE: begin
                    // Any other single key only counts toward release; a new
                    // key is accepted only after passing through IDLE.
                    if (sweep_single && (sweep_code == key_q)) begin
                        state_d = HELD;
                    end else if (4'(cnt_q + 4'd1) == DB_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Synchroniser resets to the idle (pulled-up) pin level so no
            // phantom press is seen after reset.
            rows_meta_q <= 4'b1111;
            rows_sync_q <= 4'b1111;
            div_q       <= '0;
            col_q       <= 2'd0;
            hits_q      <= 2'd0;
            first_q     <= 4'd0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_q       <= 4'd0;
            key_multi_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
            div_q       <= div_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            first_q     <= first_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            key_multi_q <= key_multi_d;
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign key       = key_q;
    assign key_valid = (state_q == HELD) || (state_q == CONFIRM_RELEASE);
    assign key_multi = key_multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3). A keypad
//   model pulls a row low whenever a pressed key's column is driven. A
//   sweep-level reference model predicts every output on every clock. A
//   table of sweep-aligned scenarios, hand sequences for asynchronous reset,
//   and randomized key patterns drive the checks.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam logic [3:0] ROT [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_multi;
    logic [15:0] press;          // bit r*4+c set = key (r,c) physically pressed

    int n_vec = 0;
    int n_bad = 0;
    int kv_rises = 0;
    logic kv_prev = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .key_valid(key_valid),
        .key_multi(key_multi)
    );

    // Keypad matrix: a row reads low when any pressed key on it sits in a driven column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    // ---------------- reference model ----------------
    int          m_cyc;           // edges since reset release
    logic [15:0] m_hist[$];       // pressed mask before each recent edge, newest first
    int          m_sweep[$];      // codes seen in the current sweep, in scan order
    int          m_res[$];        // sweep results since the last key_valid change
    logic        m_valid;
    logic [3:0]  m_key;
    logic        m_multi;
    int          m_sweeps = 0;    // total completed sweeps, never reset

    task automatic model_reset();
        m_cyc = 0;
        m_hist.delete();
        m_sweep.delete();
        m_res.delete();
        m_valid = 1'b0;
        m_key   = 4'd0;
        m_multi = 1'b0;
    endtask

    // Result encoding: -1 none, -2 multi, otherwise the key code.
    task automatic model_debounce(input int res);
        logic all_ok;
        m_res.push_back(res);
        if (m_res.size() > DB) void'(m_res.pop_front());
        if (m_res.size() == DB) begin
            all_ok = 1'b1;
            for (int i = 0; i < DB; i++) begin
                if (!m_valid) all_ok &= (m_res[i] >= 0) && (m_res[i] == res);
                else          all_ok &= (m_res[i] != int'(m_key));
            end
            if (all_ok) begin
                if (!m_valid) m_key = res[3:0];
                m_valid = !m_valid;
                m_res.delete();
            end
        end
    endtask

    task automatic model_edge(input logic [15:0] pre);
        int          c;
        int          res;
        logic [15:0] smp;
        m_hist.push_front(pre);
        if (m_hist.size() > 3) void'(m_hist.pop_back());
        if (m_cyc % SD == SD - 1) begin
            c   = (m_cyc / SD) % 4;
            // Two synchroniser stages: the sample reflects the pins two edges back.
            smp = (m_hist.size() > 2) ? m_hist[2] : 16'h0;
            for (int r = 0; r < 4; r++)
                if (smp[r*4+c]) m_sweep.push_back(r*4 + c);
            if (c == 3) begin
                res = (m_sweep.size() == 0) ? -1 :
                      (m_sweep.size() == 1) ? m_sweep[0] : -2;
                m_multi = (m_sweep.size() >= 2);
                m_sweep.delete();
                model_debounce(res);
                m_sweeps++;
            end
        end
        m_cyc++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        logic [15:0] pre;
        logic [3:0]  exp_cols;
        pre = press;
        @(posedge clk);
        #1;
        if (!reset) model_reset();
        else        model_edge(pre);
        exp_cols = ~(4'b0001 << ((m_cyc / SD) % 4));
        check("cols",      16'(cols),      16'(exp_cols));
        check("key",       16'(key),       16'(m_key));
        check("key_valid", 16'(key_valid), 16'(m_valid));
        check("key_multi", 16'(key_multi), 16'(m_multi));
        if (key_valid && !kv_prev) kv_rises++;
        kv_prev = key_valid;
    endtask

    task automatic run_sweeps(input int n);
        int target;
        int budget;
        target = m_sweeps + n;
        budget = (n + 1) * 4 * SD;
        while (m_sweeps < target && budget > 0) begin
            step();
            budget--;
        end
        if (m_sweeps < target) begin
            n_vec++;
            n_bad++;
            $display("FAIL sweep_wait: reached %0d sweeps, want %0d", m_sweeps, target);
        end
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string       name;
        logic [15:0] mask;
        int          sweeps;
        logic        exp_valid;
        logic [3:0]  exp_key;
        logic        exp_multi;
        int          exp_pulses;   // key_valid rising edges since the table started
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic [15:0] mask, input int sweeps,
                                input logic v, input logic [3:0] k, input logic m, input int p);
        vec_t e;
        e.name = name; e.mask = mask; e.sweeps = sweeps;
        e.exp_valid = v; e.exp_key = k; e.exp_multi = m; e.exp_pulses = p;
        vecs.push_back(e);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int          kind;
        //               name             mask     sw v  key    m  pulses
        add("press6_a",      16'h0040, 2, 0, 4'd0,  0, 0);
        add("press6_b",      16'h0040, 1, 1, 4'd6,  0, 1);
        add("hold6",         16'h0040, 4, 1, 4'd6,  0, 1);
        add("rel6_a",        16'h0000, 2, 1, 4'd6,  0, 1);
        add("rel6_b",        16'h0000, 1, 0, 4'd6,  0, 1);
        for (int i = 0; i < 2; i++) begin
            add("bounce_on1",  16'h0040, 1, 0, 4'd6,  0, 1);
            add("bounce_off1", 16'h0000, 1, 0, 4'd6,  0, 1);
            add("bounce_on2",  16'h0040, 2, 0, 4'd6,  0, 1);
            add("bounce_off2", 16'h0000, 1, 0, 4'd6,  0, 1);
        end
        add("multi_0_15",    16'h8001, 1, 0, 4'd6,  1, 1);
        add("multi_hold",    16'h8001, 3, 0, 4'd6,  1, 1);
        add("multi_clr",     16'h0000, 1, 0, 4'd6,  0, 1);
        add("p5",            16'h0020, 3, 1, 4'd5,  0, 2);
        add("p5_add9",       16'h0220, 2, 1, 4'd5,  1, 2);
        add("p5_add9_end",   16'h0220, 1, 0, 4'd5,  1, 2);
        add("clr",           16'h0000, 1, 0, 4'd5,  0, 2);
        add("p5_again",      16'h0020, 3, 1, 4'd5,  0, 3);
        add("glitch",        16'h0000, 1, 1, 4'd5,  0, 3);
        add("p5_back",       16'h0020, 1, 1, 4'd5,  0, 3);
        add("rel5_a",        16'h0000, 2, 1, 4'd5,  0, 3);
        add("rel5_b",        16'h0000, 1, 0, 4'd5,  0, 3);
        add("row_pair_4_7",  16'h0090, 1, 0, 4'd5,  1, 3);
        add("p15",           16'h8000, 3, 1, 4'd15, 0, 4);
        add("p15_to_3",      16'h0008, 2, 1, 4'd15, 0, 4);
        add("p15_to_3_end",  16'h0008, 1, 0, 4'd15, 0, 4);
        add("p3_a",          16'h0008, 2, 0, 4'd15, 0, 4);
        add("p3_b",          16'h0008, 1, 1, 4'd3,  0, 5);
        add("rel3",          16'h0000, 3, 0, 4'd3,  0, 5);
        add("p0",            16'h0001, 3, 1, 4'd0,  0, 6);
        add("rel0",          16'h0000, 3, 0, 4'd0,  0, 6);

        // ---- asynchronous reset with no clock edge ----
        press = 16'h0;
        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_cols",      16'(cols),      16'h000E);
        check("rst_key",       16'(key),       16'h0000);
        check("rst_key_valid", 16'(key_valid), 16'h0000);
        check("rst_key_multi", 16'(key_multi), 16'h0000);
        repeat (3) step();
        reset = 1'b1;

        // ---- column rotation: one full sweep ----
        for (int j = 0; j < 5; j++) begin
            check("rotation_cols", 16'(cols), 16'(ROT[j]));
            if (j < 4) repeat (SD) step();
        end

        // ---- table-driven scenarios, each aligned to sweep boundaries ----
        kv_rises = 0;
        foreach (vecs[i]) begin
            press = vecs[i].mask;
            run_sweeps(vecs[i].sweeps);
            check({vecs[i].name, "/key_valid"}, 16'(key_valid), 16'(vecs[i].exp_valid));
            check({vecs[i].name, "/key"},       16'(key),       16'(vecs[i].exp_key));
            check({vecs[i].name, "/key_multi"}, 16'(key_multi), 16'(vecs[i].exp_multi));
            check({vecs[i].name, "/pulses"},    16'(kv_rises),  16'(vecs[i].exp_pulses));
        end

        // ---- asynchronous reset while key 10 is held ----
        press = 16'h0400;
        run_sweeps(3);
        check("hold10_valid", 16'(key_valid), 16'h0001);
        check("hold10_key",   16'(key),       16'h000A);
        #2 reset = 1'b0;
        #1;
        check("midrst_key_valid", 16'(key_valid), 16'h0000);
        check("midrst_cols",      16'(cols),       16'h000E);
        check("midrst_key",       16'(key),        16'h0000);
        repeat (2) step();
        reset = 1'b1;
        run_sweeps(2);
        check("rearm10_early", 16'(key_valid), 16'h0000);
        run_sweeps(1);
        check("rearm10_valid", 16'(key_valid), 16'h0001);
        check("rearm10_key",   16'(key),       16'h000A);
        press = 16'h0;
        run_sweeps(3);

        // ---- randomized key patterns, sometimes changing mid-sweep ----
        for (int it = 0; it < 120; it++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 55)      m = 16'(1) << $urandom_range(0, 15);
            else if (kind < 80) m = 16'h0;
            else                m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            press = m;
            run_sweeps(int'($urandom_range(1, 5)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 15)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
